// File: rtl/vram_write_scheduler_pkg.sv
// Shared definitions for the VRAM write scheduler: widths, scheduler state encoding, entry sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_write_scheduler_pkg;

  // Shared VRAM address width used by the CPU bus decode and the GPU VRAM port.
  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_DATA_WIDTH = 8;

  // IDLE: queue empty. WAIT: entries queued, video active. DRAIN: entries queued, blanking.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  // One queued write is {address, data}.
  function automatic int entry_width(input int addr_width);
    return addr_width + VRAM_DATA_WIDTH;
  endfunction

endpackage

// File: rtl/vram_write_fifo.sv
// Synchronous FIFO holding deferred VRAM writes; head entry is presented combinationally.
// Latency: a pushed entry is visible at o_pop_dat the cycle after the push edge.
// Backpressure: push refused when full unless a pop happens on the same edge.
// Ports: clk/rst_n, i_push/i_push_dat, i_pop, o_pop_dat (head), o_level, o_full, o_empty.
module vram_write_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_dat,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_pop_dat,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;

  logic w_full;
  logic w_empty;
  logic w_do_pop;
  logic w_do_push;

  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  assign w_do_pop  = i_pop && !w_empty;
  // When full, the slot being written is the one being popped this edge; the
  // head read below still returns the old entry because the write is registered.
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

// File: rtl/vram_write_scheduler.sv
// Defers CPU VRAM writes into a FIFO and replays them one per clock only during blanking.
// Latency: strobe to vram_write_enable is 2 clocks minimum (push edge, then registered pop/issue).
// Backpressure: none toward the CPU; a write arriving at a full FIFO with no pop is dropped and
//   the sticky overflow flag is raised.
// Ports: clk, rst (async active-low); cpu_* write request; writable from video timing;
//   vram_* issue outputs; fifo_level/fifo_full status; overflow/clear_overflow; drain_done pulse.
module vram_write_scheduler
  import vram_write_scheduler_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cpu_data,
  input  logic [ADDR_WIDTH-1:0]  cpu_address,
  input  logic                   cpu_write_enable,
  input  logic                   cpu_select_vram,
  input  logic                   writable,
  output logic [7:0]             vram_data,
  output logic [ADDR_WIDTH-1:0]  vram_address,
  output logic                   vram_write_enable,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   fifo_full,
  output logic                   overflow,
  input  logic                   clear_overflow,
  output logic                   drain_done
);

  localparam int EW    = entry_width(ADDR_WIDTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  sched_state_t r_state;
  sched_state_t w_state_nxt;

  logic                  w_push_req;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_last_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [LVL_W-1:0]      w_level;
  logic [EW-1:0]         w_head;

  logic                  r_vram_we;
  logic [ADDR_WIDTH-1:0] r_vram_address;
  logic [7:0]            r_vram_data;
  logic                  r_drain_done;
  logic                  r_overflow;

  assign w_push_req = cpu_write_enable && cpu_select_vram;
  // Pop requires DRAIN (entered on an earlier writable edge) and writable on this edge,
  // so at most one write can land in the cycle after blanking ends.
  assign w_pop      = (r_state == ST_DRAIN) && writable && !w_empty;
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_last_pop = w_pop && !w_push && (w_level == LVL_W'(1));

  vram_write_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .i_push     (w_push),
    .i_push_dat ({cpu_address, cpu_data}),
    .i_pop      (w_pop),
    .o_pop_dat  (w_head),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) begin
          w_state_nxt = writable ? ST_DRAIN : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (writable) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_last_pop) begin
          w_state_nxt = ST_IDLE;
        end else if (!writable) begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Issue register: address/data hold their last issued value between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vram_we      <= 1'b0;
      r_vram_address <= '0;
      r_vram_data    <= '0;
      r_drain_done   <= 1'b0;
    end else begin
      r_vram_we    <= w_pop;
      r_drain_done <= w_last_pop;
      if (w_pop) begin
        {r_vram_address, r_vram_data} <= w_head;
      end
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clear_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign vram_write_enable = r_vram_we;
  assign vram_address      = r_vram_address;
  assign vram_data         = r_vram_data;
  assign drain_done        = r_drain_done;
  assign overflow          = r_overflow;
  assign fifo_level        = w_level;
  assign fifo_full         = w_full;

endmodule

// File: tb/tb_vram_write_scheduler.sv
module tb_vram_write_scheduler;
  import vram_write_scheduler_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = VRAM_ADDR_WIDTH;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cpu_data;
  logic [AW-1:0] cpu_address;
  logic          cpu_write_enable;
  logic          cpu_select_vram;
  logic          writable;
  logic [7:0]    vram_data;
  logic [AW-1:0] vram_address;
  logic          vram_write_enable;
  logic [LW-1:0] fifo_level;
  logic          fifo_full;
  logic          overflow;
  logic          clear_overflow;
  logic          drain_done;

  always #5 clk = ~clk;

  vram_write_scheduler #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_data          (cpu_data),
    .cpu_address       (cpu_address),
    .cpu_write_enable  (cpu_write_enable),
    .cpu_select_vram   (cpu_select_vram),
    .writable          (writable),
    .vram_data         (vram_data),
    .vram_address      (vram_address),
    .vram_write_enable (vram_write_enable),
    .fifo_level        (fifo_level),
    .fifo_full         (fifo_full),
    .overflow          (overflow),
    .clear_overflow    (clear_overflow),
    .drain_done        (drain_done)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ent_t;

  // Reference model: a queue of pending writes. A write leaves the queue on an
  // edge where writable is high and was also high on the previous edge (the first
  // writable edge only arms the drain), and appears on the VRAM port after that edge.
  ent_t          mq[$];
  bit            m_prev_wr;
  bit            m_ovf;
  bit            m_we;
  bit            m_done;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_data;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_iss    = 0;
  int   n_done   = 0;
  ent_t iss_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev_wr = 1'b0;
    m_ovf     = 1'b0;
    m_we      = 1'b0;
    m_done    = 1'b0;
    m_addr    = '0;
    m_data    = '0;
  endtask

  task automatic model_edge(input bit we, input bit sel, input bit wr, input bit clr,
                            input logic [AW-1:0] a, input logic [7:0] d);
    bit   pop;
    bit   drop;
    ent_t e;
    pop    = m_prev_wr && wr && (mq.size() > 0);
    drop   = 1'b0;
    m_we   = 1'b0;
    m_done = 1'b0;
    if (pop) begin
      e      = mq.pop_front();
      m_we   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end
    if (we && sel) begin
      if (mq.size() < DEPTH) begin
        e.addr = a;
        e.data = d;
        mq.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (pop && mq.size() == 0) m_done = 1'b1;
    m_prev_wr = wr;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    32'(vram_write_enable), 32'(m_we));
    chk({tag, ".addr"},  32'(vram_address),      32'(m_addr));
    chk({tag, ".data"},  32'(vram_data),         32'(m_data));
    chk({tag, ".level"}, 32'(fifo_level),        32'(mq.size()));
    chk({tag, ".full"},  32'(fifo_full),         32'(mq.size() == DEPTH));
    chk({tag, ".ovf"},   32'(overflow),          32'(m_ovf));
    chk({tag, ".done"},  32'(drain_done),        32'(m_done));
  endtask

  task automatic drive(input bit we, input bit sel, input bit wr, input bit clr,
                       input logic [AW-1:0] a, input logic [7:0] d);
    cpu_write_enable = we;
    cpu_select_vram  = sel;
    writable         = wr;
    clear_overflow   = clr;
    cpu_address      = a;
    cpu_data         = d;
  endtask

  // One clock: drive, take the edge, advance the model, compare 1 ns later.
  task automatic step(input string tag, input bit we, input bit sel, input bit wr, input bit clr,
                      input logic [AW-1:0] a, input logic [7:0] d);
    ent_t e;
    drive(we, sel, wr, clr, a, d);
    @(posedge clk);
    model_edge(we, sel, wr, clr, a, d);
    #1;
    check_all(tag);
    if (vram_write_enable === 1'b1) begin
      n_iss++;
      e.addr = vram_address;
      e.data = vram_data;
      iss_q.push_back(e);
    end
    if (drain_done === 1'b1) n_done++;
  endtask

  task automatic clear_counts();
    n_iss  = 0;
    n_done = 0;
    iss_q.delete();
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
  endtask

  function automatic logic [31:0] iss_addr(input int i);
    return (i < iss_q.size()) ? 32'(iss_q[i].addr) : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] iss_data(input int i);
    return (i < iss_q.size()) ? 32'(iss_q[i].data) : 32'hFFFF_FFFF;
  endfunction

  typedef struct {
    bit            we, sel, wr;
    logic [AW-1:0] a;
    logic [7:0]    d;
    bit            e_we;
    logic [AW-1:0] e_a;
    logic [7:0]    e_d;
    int            e_lvl;
    bit            e_done;
  } vec_t;

  function automatic vec_t mkv(input bit we, input bit sel, input bit wr,
                               input logic [AW-1:0] a, input logic [7:0] d,
                               input bit e_we, input logic [AW-1:0] e_a, input logic [7:0] e_d,
                               input int e_lvl, input bit e_done);
    vec_t v;
    v.we = we; v.sel = sel; v.wr = wr; v.a = a; v.d = d;
    v.e_we = e_we; v.e_a = e_a; v.e_d = e_d; v.e_lvl = e_lvl; v.e_done = e_done;
    return v;
  endfunction

  vec_t tbl[9];

  initial begin
    bit wr_r;
    bit we_r;
    bit sel_r;
    bit clr_r;

    // Single write during blanking, a non-VRAM strobe, then a write during active video.
    tbl[0] = mkv(0, 0, 1, 16'h0000, 8'h00, 0, 16'h0000, 8'h00, 0, 0);
    tbl[1] = mkv(1, 1, 1, 16'h0010, 8'hA5, 0, 16'h0000, 8'h00, 1, 0);
    tbl[2] = mkv(0, 0, 1, 16'h0000, 8'h00, 1, 16'h0010, 8'hA5, 0, 1);
    tbl[3] = mkv(0, 0, 1, 16'h0000, 8'h00, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[4] = mkv(1, 0, 1, 16'h0020, 8'h5A, 0, 16'h0010, 8'hA5, 0, 0);
    tbl[5] = mkv(1, 1, 0, 16'h0030, 8'h3C, 0, 16'h0010, 8'hA5, 1, 0);
    tbl[6] = mkv(0, 0, 0, 16'h0000, 8'h00, 0, 16'h0010, 8'hA5, 1, 0);
    tbl[7] = mkv(0, 0, 1, 16'h0000, 8'h00, 0, 16'h0010, 8'hA5, 1, 0);
    tbl[8] = mkv(0, 0, 1, 16'h0000, 8'h00, 1, 16'h0030, 8'h3C, 0, 1);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

    // ---- Table vectors ----
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].sel, tbl[i].wr, 1'b0, tbl[i].a, tbl[i].d);
      @(posedge clk);
      model_edge(tbl[i].we, tbl[i].sel, tbl[i].wr, 1'b0, tbl[i].a, tbl[i].d);
      #1;
      chk($sformatf("vec%0d.we", i),    32'(vram_write_enable), 32'(tbl[i].e_we));
      chk($sformatf("vec%0d.addr", i),  32'(vram_address),      32'(tbl[i].e_a));
      chk($sformatf("vec%0d.data", i),  32'(vram_data),         32'(tbl[i].e_d));
      chk($sformatf("vec%0d.level", i), 32'(fifo_level),        32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d.done", i),  32'(drain_done),        32'(tbl[i].e_done));
      chk($sformatf("vec%0d.ovf", i),   32'(overflow),          32'(0));
    end

    // ---- Five deferred writes, then one blanking window ----
    do_reset();
    for (int i = 0; i < 5; i++) step("t2.fill", 1, 1, 0, 0, AW'(16'h0100 + i), 8'(i + 1));
    chk("t2.level_queued", 32'(fifo_level), 32'd5);
    chk("t2.no_write_active", 32'(n_iss), 32'd0);
    for (int i = 0; i < 8; i++) step("t2.drain", 0, 0, 1, 0, '0, '0);
    chk("t2.write_count", 32'(n_iss), 32'd5);
    chk("t2.done_count", 32'(n_done), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t2.order_addr%0d", i), iss_addr(i), 32'(16'h0100 + i));
      chk($sformatf("t2.order_data%0d", i), iss_data(i), 32'(i + 1));
    end

    // ---- Overflow: DEPTH+2 writes while active ----
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step("t3.fill", 1, 1, 0, 0, AW'(16'h0200 + i), 8'(8'h40 + i));
    chk("t3.full", 32'(fifo_full), 32'd1);
    chk("t3.overflow", 32'(overflow), 32'd1);
    chk("t3.level", 32'(fifo_level), 32'(DEPTH));
    for (int i = 0; i < DEPTH + 4; i++) step("t3.drain", 0, 0, 1, 0, '0, '0);
    chk("t3.write_count", 32'(n_iss), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("t3.order_addr%0d", i), iss_addr(i), 32'(16'h0200 + i));
    chk("t3.overflow_sticky", 32'(overflow), 32'd1);
    step("t3.clear", 0, 0, 1, 1, '0, '0);
    chk("t3.overflow_cleared", 32'(overflow), 32'd0);

    // ---- Short window: 4 writable edges with 10 queued ----
    do_reset();
    for (int i = 0; i < 10; i++) step("t4.fill", 1, 1, 0, 0, AW'(16'h0300 + i), 8'(i));
    for (int i = 0; i < 4; i++) step("t4.win", 0, 0, 1, 0, '0, '0);
    for (int i = 0; i < 6; i++) step("t4.active", 0, 0, 0, 0, '0, '0);
    chk("t4.window_bounded", 32'(n_iss >= 3 && n_iss <= 5), 32'd1);
    chk("t4.level_after_window", 32'(fifo_level), 32'(10 - n_iss));
    for (int i = 0; i < 16; i++) step("t4.win2", 0, 0, 1, 0, '0, '0);
    chk("t4.total_writes", 32'(n_iss), 32'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t4.order_addr%0d", i), iss_addr(i), 32'(16'h0300 + i));

    // ---- Full FIFO draining with a push every cycle ----
    do_reset();
    for (int i = 0; i < DEPTH; i++) step("t5.fill", 1, 1, 0, 0, AW'(16'h0400 + i), 8'(i));
    step("t5.arm", 0, 0, 1, 0, '0, '0);
    clear_counts();
    for (int i = 0; i < 20; i++) step("t5.stream", 1, 1, 1, 0, AW'(16'h0480 + i), 8'(i));
    chk("t5.level_held", 32'(fifo_level), 32'(DEPTH));
    chk("t5.no_overflow", 32'(overflow), 32'd0);
    chk("t5.write_count", 32'(n_iss), 32'd20);
    chk("t5.first_addr", iss_addr(0), 32'h0400);
    chk("t5.wrapped_addr", iss_addr(DEPTH), 32'h0480);

    // ---- Async reset in the middle of a drain ----
    do_reset();
    for (int i = 0; i < 8; i++) step("t6.fill", 1, 1, 0, 0, AW'(16'h0500 + i), 8'(i));
    for (int i = 0; i < 3; i++) step("t6.drain", 0, 0, 1, 0, '0, '0);
    chk("t6.level_before", 32'(fifo_level), 32'd6);
    chk("t6.we_before", 32'(vram_write_enable), 32'd1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    chk("t6.we_async", 32'(vram_write_enable), 32'd0);
    chk("t6.level_async", 32'(fifo_level), 32'd0);
    chk("t6.addr_async", 32'(vram_address), 32'd0);
    chk("t6.done_async", 32'(drain_done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    for (int i = 0; i < 6; i++) step("t6.after", 0, 0, 1, 0, '0, '0);
    chk("t6.no_stale", 32'(n_iss), 32'd0);

    // ---- Randomized traffic against the model ----
    do_reset();
    wr_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) wr_r = ~wr_r;
      we_r  = ($urandom_range(0, 1) == 1);
      sel_r = ($urandom_range(0, 3) != 0);
      clr_r = ($urandom_range(0, 15) == 0);
      step("rnd", we_r, sel_r, wr_r, clr_r, AW'($urandom), 8'($urandom));
    end
    for (int i = 0; i < DEPTH + 4; i++) step("rnd.flush", 0, 0, 1, 0, '0, '0);
    chk("rnd.empty_at_end", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
